// File: rtl/local_packet_assembler.sv
// Reassembles the router's local flit stream into packets and queues them for the neuron core.
// A single pending/hold register sits between the assembler and a first-word fall-through FIFO.
//
// state       | meaning
// ST_COLLECT  | no completed packet pending; flits go into the assembly register
// ST_COMPLETE | packet completed last cycle; push now, or park it in hold if the FIFO is full
// ST_HOLD     | packet parked (hold_valid=1); flits are dropped until the FIFO has space
module local_packet_assembler #(
    parameter int flit_size   = 4,
    parameter int packet_size = 32,
    parameter int fifo_depth  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [flit_size-1:0]   flit_in,
    input  logic                   write_req,
    output logic                   neuron_full,
    output logic [packet_size-1:0] packet_out,
    output logic                   packet_valid,
    input  logic                   packet_ready,
    output logic                   overflow
);
    localparam int flits_per_packet = packet_size / flit_size;
    localparam int cnt_w = (flits_per_packet > 1) ? $clog2(flits_per_packet) : 1;
    localparam int ptr_w = $clog2(fifo_depth);

    localparam logic [1:0] ST_COLLECT  = 2'd0;
    localparam logic [1:0] ST_COMPLETE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [1:0]             state;
    logic [cnt_w-1:0]       flit_cnt;
    logic [packet_size-1:0] asm_data;
    logic [packet_size-1:0] asm_next;
    logic [packet_size-1:0] pend_data;
    logic [packet_size-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]       wr_ptr;
    logic [ptr_w-1:0]       rd_ptr;
    logic [ptr_w:0]         fifo_count;
    logic                   hold_valid;
    logic                   flit_accept;
    logic                   last_flit;
    logic                   fifo_full;
    logic                   fifo_space;
    logic                   fifo_push;
    logic                   fifo_pop;

    assign hold_valid   = (state == ST_HOLD);
    assign flit_accept  = write_req & ~hold_valid;
    assign last_flit    = (flit_cnt == cnt_w'(flits_per_packet - 1));
    assign fifo_full    = (fifo_count == (ptr_w + 1)'(fifo_depth));
    assign packet_valid = (fifo_count != '0);
    assign fifo_pop     = packet_valid & packet_ready;
    // A pop in the same cycle frees the slot the pending packet needs.
    assign fifo_space   = ~fifo_full | fifo_pop;
    assign fifo_push    = (state != ST_COLLECT) & fifo_space;
    assign neuron_full  = fifo_full | hold_valid;
    assign packet_out   = packet_valid ? mem[rd_ptr] : '0;

    // First flit of a packet lands in the most significant slot.
    always_comb begin
        asm_next = asm_data;
        asm_next[packet_size - 1 - int'(flit_cnt) * flit_size -: flit_size] = flit_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_COLLECT;
            flit_cnt   <= '0;
            asm_data   <= '0;
            pend_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (write_req & hold_valid) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_COMPLETE: state <= fifo_space ? ST_COLLECT : ST_HOLD;
                ST_HOLD:     if (fifo_space) state <= ST_COLLECT;
                default:     ;
            endcase

            if (flit_accept) begin
                if (last_flit) begin
                    flit_cnt  <= '0;
                    asm_data  <= '0;
                    pend_data <= asm_next;
                    state     <= ST_COMPLETE;
                end else begin
                    flit_cnt <= flit_cnt + 1'b1;
                    asm_data <= asm_next;
                end
            end

            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push & ~reset) begin
            mem[wr_ptr] <= pend_data;
        end
    end

endmodule

// File: tb/tb_local_packet_assembler.sv
// Directed plus randomized bench for local_packet_assembler, checked every cycle against a
// queue-based packet model.
module tb_local_packet_assembler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  flit_in;
    logic        write_req;
    logic        neuron_full;
    logic [31:0] packet_out;
    logic        packet_valid;
    logic        packet_ready;
    logic        overflow;

    always #5 clk = ~clk;

    local_packet_assembler dut (
        .clk          (clk),
        .reset        (reset),
        .flit_in      (flit_in),
        .write_req    (write_req),
        .neuron_full  (neuron_full),
        .packet_out   (packet_out),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .overflow     (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mq[$];
    logic [31:0] popped[$];
    int          m_k;
    logic [31:0] m_acc;
    logic [31:0] m_pdata;
    bit          m_pend;
    bit          m_hold;
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_k = 0;
        m_acc = '0;
        m_pdata = '0;
        m_pend = 0;
        m_hold = 0;
        m_ovf = 0;
    endtask

    task automatic compare_outputs();
        logic [31:0] head;
        head = (mq.size() > 0) ? mq[0] : 32'h0;
        check("packet_valid", packet_valid, mq.size() > 0);
        check("packet_out", packet_out, head);
        check("neuron_full", neuron_full, (mq.size() == 4) || m_hold);
        check("overflow", overflow, m_ovf);
    endtask

    // Effect of one clock edge on the packet-level model.
    task automatic model_step(input logic wr, input logic [3:0] f, input logic rdy);
        bit was_hold;
        bit pop;
        bit space;
        was_hold = m_hold;
        pop      = rdy && (mq.size() > 0);
        space    = (mq.size() < 4) || pop;
        if (pop) void'(mq.pop_front());
        if (m_pend || m_hold) begin
            if (space) begin
                mq.push_back(m_pdata);
                m_pend = 0;
                m_hold = 0;
            end else begin
                m_hold = 1;
                m_pend = 0;
            end
        end
        if (wr) begin
            if (was_hold) begin
                m_ovf = 1;
            end else begin
                m_acc = {m_acc[27:0], f};
                m_k++;
                if (m_k == 8) begin
                    m_pend  = 1;
                    m_pdata = m_acc;
                    m_k     = 0;
                    m_acc   = '0;
                end
            end
        end
    endtask

    task automatic cycle(input logic wr, input logic [3:0] f, input logic rdy);
        reset        = 1'b0;
        write_req    = wr;
        flit_in      = f;
        packet_ready = rdy;
        @(negedge clk);
        compare_outputs();
        if (rdy && packet_valid) popped.push_back(packet_out);
        model_step(wr, f, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        write_req    = 1'b0;
        flit_in      = 4'h0;
        packet_ready = 1'b0;
        @(negedge clk);
        compare_outputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] data, input logic rdy);
        for (int i = 0; i < 8; i++) cycle(1'b1, data[31 - 4 * i -: 4], rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, rdy);
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = 'x;
        if (popped.size() > 0) got = popped.pop_front();
        check(tag, got, exp);
    endtask

    initial begin
        reset        = 1'b1;
        write_req    = 1'b0;
        flit_in      = 4'h0;
        packet_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        do_reset();
        check("rst_valid", packet_valid, 1'b0);
        check("rst_full", neuron_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_out", packet_out, 32'h0);

        // single packet and its latency
        send_packet(32'h12345678, 1'b1);
        check("lat_not_yet", packet_valid, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        check("lat_valid", packet_valid, 1'b1);
        check("single_out", packet_out, 32'h12345678);
        idle(2, 1'b1);
        expect_pop("single_pop", 32'h12345678);
        check("single_empty", packet_valid, 1'b0);

        // gapped flits
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(4'hA + i), 1'b1);
        idle(3, 1'b1);
        cycle(1'b1, 4'hE, 1'b1);
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b1, 4'h0, 1'b1);
        cycle(1'b1, 4'h9, 1'b1);
        idle(3, 1'b1);
        expect_pop("gapped_pop", 32'hABCDEF09);

        // fill to full, partial packet held across back-pressure
        send_packet(32'h11111111, 1'b0);
        send_packet(32'h22222222, 1'b0);
        send_packet(32'h33333333, 1'b0);
        send_packet(32'h44444444, 1'b0);
        idle(1, 1'b0);
        check("fill_full", neuron_full, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h5, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        check("fill_freed", neuron_full, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'h5, 1'b0);
        idle(2, 1'b0);
        check("fill_full_again", neuron_full, 1'b1);
        idle(6, 1'b1);
        expect_pop("fill_pop1", 32'h11111111);
        expect_pop("fill_pop2", 32'h22222222);
        expect_pop("fill_pop3", 32'h33333333);
        expect_pop("fill_pop4", 32'h44444444);
        expect_pop("fill_pop5", 32'h55555555);

        // hold path, then overflow while holding
        send_packet(32'h01234567, 1'b0);
        send_packet(32'h89ABCDEF, 1'b0);
        send_packet(32'h0F1E2D3C, 1'b0);
        send_packet(32'h4B5A6978, 1'b0);
        send_packet(32'hCAFEBABE, 1'b0);
        idle(1, 1'b0);
        check("hold_full", neuron_full, 1'b1);
        cycle(1'b1, 4'hF, 1'b0);
        check("ovf_set", overflow, 1'b1);
        idle(2, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        check("hold_refill_full", neuron_full, 1'b1);
        idle(6, 1'b1);
        expect_pop("hold_pop1", 32'h01234567);
        expect_pop("hold_pop2", 32'h89ABCDEF);
        expect_pop("hold_pop3", 32'h0F1E2D3C);
        expect_pop("hold_pop4", 32'h4B5A6978);
        expect_pop("hold_pop5", 32'hCAFEBABE);
        send_packet(32'h13572468, 1'b1);
        idle(3, 1'b1);
        expect_pop("after_ovf_pop", 32'h13572468);
        check("ovf_still", overflow, 1'b1);

        // reset mid-operation
        send_packet(32'hAAAA5555, 1'b0);
        send_packet(32'h5555AAAA, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 4'(i), 1'b0);
        do_reset();
        check("mid_rst_valid", packet_valid, 1'b0);
        check("mid_rst_full", neuron_full, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        send_packet(32'h87654321, 1'b1);
        idle(3, 1'b1);
        expect_pop("mid_rst_pop", 32'h87654321);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 99) < 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
